// File: rtl/csr_unit.sv
// CSR read-modify-write sequencer: reads a status register, applies RW/RS/RC,
// writes the result back and returns the old value over a valid/ready response.
module csr_unit #(
  parameter logic [15:0] RO_MASK = 16'h0000
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_req_valid,
  output logic        O_req_ready,
  input  logic [1:0]  I_op,
  input  logic [3:0]  I_idx,
  input  logic [31:0] I_src,
  input  logic        I_nowrite,
  output logic        O_resp_valid,
  input  logic        I_resp_ready,
  output logic [31:0] O_rdata,
  output logic        O_err,
  output logic [3:0]  O_msr_rs,
  input  logic [31:0] I_msr_data,
  output logic [3:0]  O_msr_rd,
  output logic [31:0] O_msr_data,
  output logic        O_msr_wen
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] OP_ILL = 2'b00;
  localparam logic [1:0] OP_RW  = 2'b01;
  localparam logic [1:0] OP_RS  = 2'b10;
  localparam logic [1:0] OP_RC  = 2'b11;

  state_t      state_r;
  state_t      state_s;
  logic [1:0]  op_r;
  logic [3:0]  idx_r;
  logic [31:0] src_r;
  logic        nowrite_r;
  logic [31:0] old_r;
  logic [31:0] rdata_r;
  logic        err_r;

  logic        legal_s;
  logic        ro_s;
  logic        intend_s;
  logic        err_s;
  logic [31:0] new_s;
  logic        wen_s;

  // Decode legality, read-only status, write intent and the new value.
  always_comb begin
    legal_s  = (op_r != OP_ILL);
    ro_s     = (idx_r == 4'd0) | RO_MASK[idx_r];
    intend_s = 1'b0;
    new_s    = 32'd0;
    case (op_r)
      OP_RW: begin
        intend_s = 1'b1;
        new_s    = src_r;
      end
      OP_RS: begin
        intend_s = ~nowrite_r;
        new_s    = old_r | src_r;
      end
      OP_RC: begin
        intend_s = ~nowrite_r;
        new_s    = old_r & ~src_r;
      end
      default: begin
        intend_s = 1'b0;
        new_s    = 32'd0;
      end
    endcase
    // A suppressed RS/RC never reports a read-only violation.
    err_s = ~legal_s | (intend_s & ro_s);
    wen_s = (state_r == S_WRITE) & intend_s & ~ro_s;
  end

  // State register.
  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (I_req_valid) begin
          state_s = S_READ;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_READ:  state_s = S_WRITE;
      S_WRITE: state_s = S_RESP;
      S_RESP: begin
        if (I_resp_ready) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_RESP;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Request latch, old-value capture and response registers.
  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      op_r      <= 2'b00;
      idx_r     <= 4'd0;
      src_r     <= 32'd0;
      nowrite_r <= 1'b0;
      old_r     <= 32'd0;
      rdata_r   <= 32'd0;
      err_r     <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (I_req_valid) begin
            op_r      <= I_op;
            idx_r     <= I_idx;
            src_r     <= I_src;
            nowrite_r <= I_nowrite;
          end
        end
        S_READ: begin
          old_r <= (idx_r == 4'd0) ? 32'd0 : I_msr_data;
        end
        S_WRITE: begin
          rdata_r <= legal_s ? old_r : 32'd0;
          err_r   <= err_s;
        end
        default: begin
          rdata_r <= rdata_r;
        end
      endcase
    end
  end

  assign O_req_ready  = (state_r == S_IDLE);
  assign O_resp_valid = (state_r == S_RESP);
  assign O_rdata      = rdata_r;
  assign O_err        = err_r;
  assign O_msr_rs     = (state_r == S_IDLE) ? 4'd0 : idx_r;
  assign O_msr_wen    = wen_s;
  assign O_msr_rd     = (state_r == S_WRITE) ? idx_r : 4'd0;
  assign O_msr_data   = (state_r == S_WRITE) ? new_s : 32'd0;

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: the bench owns the status register file and
// an independent array model that predicts every response and write.
module tb_csr_unit;

  localparam logic [15:0] RO = 16'h0004;

  logic        I_clk = 1'b0;
  logic        I_rst = 1'b0;
  logic        I_req_valid = 1'b0;
  logic        O_req_ready;
  logic [1:0]  I_op = 2'b00;
  logic [3:0]  I_idx = 4'd0;
  logic [31:0] I_src = 32'd0;
  logic        I_nowrite = 1'b0;
  logic        O_resp_valid;
  logic        I_resp_ready = 1'b1;
  logic [31:0] O_rdata;
  logic        O_err;
  logic [3:0]  O_msr_rs;
  logic [31:0] I_msr_data;
  logic [3:0]  O_msr_rd;
  logic [31:0] O_msr_data;
  logic        O_msr_wen;

  logic [31:0] tb_msr [16] = '{default: 32'd0};
  logic [31:0] ref_msr [16];
  logic [15:0] ro_mask = RO;
  int tests = 0;
  int fails = 0;
  int wen_cnt = 0;
  int bad_wen = 0;
  logic [3:0]  wen_idx = 4'd0;
  logic [31:0] wen_data = 32'd0;

  always #5 I_clk = ~I_clk;

  csr_unit #(.RO_MASK(RO)) dut (
    .I_clk(I_clk), .I_rst(I_rst),
    .I_req_valid(I_req_valid), .O_req_ready(O_req_ready),
    .I_op(I_op), .I_idx(I_idx), .I_src(I_src), .I_nowrite(I_nowrite),
    .O_resp_valid(O_resp_valid), .I_resp_ready(I_resp_ready),
    .O_rdata(O_rdata), .O_err(O_err),
    .O_msr_rs(O_msr_rs), .I_msr_data(I_msr_data),
    .O_msr_rd(O_msr_rd), .O_msr_data(O_msr_data), .O_msr_wen(O_msr_wen)
  );

  // Status register file: entry 0 reads as zero, synchronous write port.
  assign I_msr_data = (O_msr_rs == 4'd0) ? 32'd0 : tb_msr[O_msr_rs];

  always @(posedge I_clk) begin
    if (O_msr_wen) begin
      wen_cnt  <= wen_cnt + 1;
      wen_idx  <= O_msr_rd;
      wen_data <= O_msr_data;
      if (O_msr_rd != 4'd0) tb_msr[O_msr_rd] <= O_msr_data;
    end
  end

  // A write strobe must never coincide with the idle or response phase.
  always @(negedge I_clk) begin
    if (O_msr_wen && (O_req_ready || O_resp_valid)) bad_wen <= bad_wen + 1;
  end

  task automatic do_req(input logic [1:0] op, input logic [3:0] idx,
                        input logic [31:0] src, input logic nw, input int hold);
    logic [31:0] old, nv, e_rdata, r_hold;
    logic e_err, e_wr, intends, ro, e_hold;
    int k, w0, bad;
    old     = (idx == 4'd0) ? 32'd0 : ref_msr[idx];
    ro      = (idx == 4'd0) || ro_mask[idx];
    intends = (op == 2'b01) || ((op != 2'b00) && !nw);
    e_wr    = (op != 2'b00) && intends && !ro;
    if (op == 2'b01)      nv = src;
    else if (op == 2'b10) nv = old | src;
    else if (op == 2'b11) nv = old & ~src;
    else                  nv = 32'd0;
    e_rdata = (op == 2'b00) ? 32'd0 : old;
    e_err   = (op == 2'b00) || (intends && ro);

    k = 0;
    while (!O_req_ready && k < 20) begin @(negedge I_clk); k++; end
    tests++;
    if (k >= 20) begin fails++; $display("FAIL idle_wait: req_ready=%0b required 1", O_req_ready); end

    w0 = wen_cnt;
    I_req_valid = 1'b1; I_op = op; I_idx = idx; I_src = src; I_nowrite = nw;
    I_resp_ready = (hold == 0);
    @(negedge I_clk);
    I_req_valid = 1'b0;
    I_op = 2'($urandom_range(0, 3)); I_idx = 4'($urandom_range(0, 15));
    I_src = $urandom; I_nowrite = 1'($urandom_range(0, 1));
    tests++;
    if (O_req_ready !== 1'b0) begin fails++; $display("FAIL busy_ready: got %0b required 0", O_req_ready); end

    k = 1;
    while (!O_resp_valid && k < 10) begin @(negedge I_clk); k++; end
    tests++;
    if (k !== 3) begin fails++; $display("FAIL latency: resp after %0d cycles required 3", k); end
    tests++;
    if (O_rdata !== e_rdata) begin fails++; $display("FAIL rdata op=%0d idx=%0d: got %h required %h", op, idx, O_rdata, e_rdata); end
    tests++;
    if (O_err !== e_err) begin fails++; $display("FAIL err op=%0d idx=%0d nw=%0b: got %0b required %0b", op, idx, nw, O_err, e_err); end
    tests++;
    if ((wen_cnt - w0) !== (e_wr ? 1 : 0)) begin fails++; $display("FAIL wen_count op=%0d idx=%0d: got %0d required %0d", op, idx, wen_cnt - w0, e_wr ? 1 : 0); end
    if (e_wr) begin
      tests++;
      if ({wen_idx, wen_data} !== {idx, nv}) begin fails++; $display("FAIL wdata: got idx %0d data %h required idx %0d data %h", wen_idx, wen_data, idx, nv); end
      ref_msr[idx] = nv;
    end

    if (hold > 0) begin
      r_hold = O_rdata; e_hold = O_err;
      repeat (hold) begin
        I_req_valid = 1'b1; I_op = 2'b01; I_idx = 4'($urandom_range(1, 15)); I_src = $urandom;
        @(negedge I_clk);
        tests++;
        if ({O_resp_valid, O_req_ready, O_rdata, O_err} !== {1'b1, 1'b0, r_hold, e_hold}) begin
          fails++;
          $display("FAIL hold: valid=%0b ready=%0b rdata=%h err=%0b required 1 0 %h %0b", O_resp_valid, O_req_ready, O_rdata, O_err, r_hold, e_hold);
        end
      end
      I_req_valid = 1'b0; I_resp_ready = 1'b1;
    end
    @(negedge I_clk);
    tests++;
    if ({O_req_ready, O_resp_valid} !== 2'b10) begin fails++; $display("FAIL return_idle: ready=%0b valid=%0b required 1 0", O_req_ready, O_resp_valid); end

    bad = 0;
    for (int i = 0; i < 16; i++) if (tb_msr[i] !== ref_msr[i] && i != 0) bad++;
    tests++;
    if (bad != 0 || (wen_cnt - w0) !== (e_wr ? 1 : 0)) begin
      fails++; $display("FAIL file: %0d entries differ, writes %0d required %0d", bad, wen_cnt - w0, e_wr ? 1 : 0);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 16; i++) ref_msr[i] = 32'd0;
    I_rst = 1'b0;
    repeat (2) @(negedge I_clk);
    tests++;
    if ({O_req_ready, O_resp_valid, O_rdata, O_err, O_msr_wen, O_msr_rs, O_msr_rd, O_msr_data} !==
        {1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0}) begin
      fails++;
      $display("FAIL reset_outputs: ready=%0b valid=%0b rdata=%h err=%0b wen=%0b rs=%0d rd=%0d wdata=%h",
               O_req_ready, O_resp_valid, O_rdata, O_err, O_msr_wen, O_msr_rs, O_msr_rd, O_msr_data);
    end
    I_rst = 1'b1;
    @(negedge I_clk);
  endtask

  task automatic test_reset_mid_write();
    int w0;
    do_req(2'b01, 4'd9, 32'h0000_1111, 1'b0, 0);
    w0 = wen_cnt;
    I_req_valid = 1'b1; I_op = 2'b01; I_idx = 4'd9; I_src = 32'hA5A5_5A5A; I_nowrite = 1'b0;
    @(negedge I_clk);
    I_req_valid = 1'b0;
    @(negedge I_clk);
    tests++;
    if (O_msr_wen !== 1'b1) begin fails++; $display("FAIL mid_write_wen: got %0b required 1", O_msr_wen); end
    #2 I_rst = 1'b0;
    #1;
    tests++;
    if ({O_msr_wen, O_req_ready, O_resp_valid} !== 3'b010) begin
      fails++; $display("FAIL async_reset: wen=%0b ready=%0b valid=%0b required 0 1 0", O_msr_wen, O_req_ready, O_resp_valid);
    end
    @(negedge I_clk);
    I_rst = 1'b1;
    @(negedge I_clk);
    tests++;
    if (tb_msr[9] !== ref_msr[9] || wen_cnt !== w0) begin
      fails++; $display("FAIL reset_drops_write: msr9=%h required %h writes %0d", tb_msr[9], ref_msr[9], wen_cnt - w0);
    end
  endtask

  task automatic test_rw();
    do_req(2'b01, 4'd5, 32'h0000_00F0, 1'b0, 0);
    do_req(2'b01, 4'd5, 32'h1234_5678, 1'b0, 0);
    do_req(2'b10, 4'd5, 32'h0000_0000, 1'b0, 0);
  endtask

  task automatic test_rs_rc();
    do_req(2'b01, 4'd3, 32'hFF00_00FF, 1'b0, 0);
    do_req(2'b10, 4'd3, 32'h0F00_0000, 1'b0, 0);
    do_req(2'b11, 4'd3, 32'h0000_000F, 1'b0, 0);
    do_req(2'b10, 4'd3, 32'hFFFF_FFFF, 1'b1, 0);
    do_req(2'b11, 4'd3, 32'hFFFF_FFFF, 1'b1, 0);
  endtask

  task automatic test_read_only();
    do_req(2'b01, 4'd0, 32'hDEAD_BEEF, 1'b0, 0);
    do_req(2'b01, 4'd2, 32'h5555_AAAA, 1'b0, 0);
    do_req(2'b10, 4'd2, 32'h0000_0001, 1'b1, 0);
    do_req(2'b11, 4'd2, 32'h0000_0001, 1'b0, 0);
  endtask

  task automatic test_illegal();
    do_req(2'b01, 4'd7, 32'hCAFE_F00D, 1'b0, 0);
    do_req(2'b00, 4'd7, 32'h1111_2222, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    do_req(2'b10, 4'd5, 32'h8000_0000, 1'b0, 5);
    do_req(2'b00, 4'd4, 32'h0000_0001, 1'b0, 2);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      do_req(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), $urandom,
             1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    end
  endtask

  initial begin
    test_reset();
    test_rw();
    test_rs_rc();
    test_read_only();
    test_illegal();
    test_backpressure();
    test_reset_mid_write();
    test_random();
    tests++;
    if (bad_wen !== 0) begin fails++; $display("FAIL stray_wen: got %0d strobes outside WRITE required 0", bad_wen); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/csr_unit.md
# csr_unit

Sequencer that executes CSR-style read-modify-write instructions against the 16-entry machine status register file (entry 0 hard-wired to zero, entries 1-15 writable, one combinational read port, one synchronous write port). It sits between the execute stage and the status register file. It accepts one request at a time, reads the old value, computes the new value, writes it back, and returns the old value to the pipeline over a valid/ready response handshake.

## Interface
Parameters:
- RO_MASK, 16'h0000: bit i set marks index i read-only. Bit 0 is ignored because index 0 is always read-only.

Ports:
- I_clk  in  1  clock; all state changes on the rising edge
- I_rst  in  1  reset, asynchronous, active-low
- I_req_valid  in  1  request present
- O_req_ready  out  1  unit idle and able to accept a request
- I_op  in  2  01 RW (write), 10 RS (set bits), 11 RC (clear bits), 00 illegal
- I_idx  in  4  status register index
- I_src  in  32  operand (rs1 value or zero-extended immediate)
- I_nowrite  in  1  suppress the write for RS/RC (source is x0 / imm 0); ignored for RW
- O_resp_valid  out  1  response present
- I_resp_ready  in  1  consumer accepts the response
- O_rdata  out  32  old register value
- O_err  out  1  illegal op, or a write attempt to a read-only index
- O_msr_rs  out  4  file read index
- I_msr_data  in  32  file read data (combinational)
- O_msr_rd  out  4  file write index
- O_msr_data  out  32  file write data
- O_msr_wen  out  1  file write enable

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE: O_req_ready=1. On I_req_valid, latch op, idx, src and nowrite, then go to READ.
- READ: O_msr_rs = latched idx. Capture I_msr_data into the old register. Force the captured value to 0 when idx==0. Go to WRITE.
- WRITE: compute new value and decide the write.
  - RW: new = src
  - RS: new = old | src
  - RC: new = old & ~src
  - Write is performed (O_msr_wen=1, O_msr_rd=idx, O_msr_data=new) only if all of:
    - op is legal
    - not (op is RS or RC and nowrite=1)
    - idx is not read-only
  - err = (op==00) | (a write was intended and idx is read-only). An RS/RC with nowrite=1 to a read-only index is not an error.
  - Go to RESP.
- RESP: O_resp_valid=1 with O_rdata=old and O_err=err.
  - O_rdata=0 when op==00.
  - On I_resp_ready, return to IDLE.
  - Otherwise hold RESP; outputs stay stable until accepted.
- O_msr_wen is decoded combinationally from the state register and latched fields. It is never 1 outside WRITE and is high for exactly one cycle per write.
- O_msr_rs outputs the latched idx in every state except IDLE, where it outputs 0.
- No request is accepted outside IDLE. I_req_valid there is ignored and the request is not lost by this unit; the upstream stage holds it.

## Timing
- Reset values: state IDLE, O_req_ready=1, O_resp_valid=0, O_rdata=0, O_err=0, O_msr_wen=0, O_msr_rs=0, O_msr_rd=0, O_msr_data=0, all latched fields 0.
- Reset mid-operation returns to IDLE immediately (asynchronously). A pending write is dropped and O_msr_wen falls without waiting for a clock.
- Cycle-level latency:
  - Accept at edge N (I_req_valid & O_req_ready).
  - READ during N..N+1.
  - WRITE during N+1..N+2; the file updates at edge N+2.
  - O_resp_valid is high from N+2.
  - With I_resp_ready=1, the unit is back in IDLE after edge N+3 and accepts a new request at N+4.
- Sustained throughput: 1 request per 4 cycles.
- Read-after-write: a request that follows a write to the same index reads the new value. READ always occurs at least 2 cycles after the previous WRITE edge.

## Test plan
- Reset: assert I_rst=0 for 2 cycles. Required: all outputs at their reset values and O_req_ready=1. Apply one mid-WRITE reset. Required: O_msr_wen drops asynchronously and the file is unchanged.
- RW: msr[5]=0x0000_00F0, then RW idx 5, src 0x1234_5678. Required: a single O_msr_wen pulse with data 0x1234_5678 and O_rdata=0x0000_00F0 at resp. Back-to-back RS idx 5, src 0: reads 0x1234_5678.
- RS/RC: msr[3]=0xFF00_00FF.
  - RS src 0x0F00_0000: writes 0xFF00_00FF | 0x0F00_0000 = 0xFF00_00FF (no bit changes).
  - RC src 0x0000_000F: writes 0xFF00_00F0 and returns 0xFF00_00FF.
  - RS with nowrite=1: O_msr_wen stays 0 throughout.
- Index 0 / read-only: RW idx 0, src 0xDEAD_BEEF. Required: O_rdata=0, O_err=1, no write. With RO_MASK=16'h0004, RW idx 2: O_err=1, no write. RS idx 2 with nowrite=1: O_err=0.
- Illegal op: op 00 idx 7. Required: O_err=1, O_rdata=0, no write.
- Backpressure: hold I_resp_ready=0 for 5 cycles. Required: O_resp_valid, O_rdata and O_err stable, O_req_ready=0, and a concurrent I_req_valid ignored. Release I_resp_ready. Required: IDLE on the next edge.
